// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with optional hardwired zero register,
// write-to-read bypass and a per-register busy scoreboard.
module reg_file_param #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             regwrite,
    input  logic [AW-1:0]    wr,
    input  logic [WIDTH-1:0] wd,
    input  logic             set_busy,
    input  logic [AW-1:0]    set_addr,
    output logic             busy1,
    output logic             busy2,
    output logic [DEPTH-1:0] busy_vec
);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy;
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (ZERO_REG && i == 0) begin : g_zero
            assign regs[i] = '0;
            assign busy[i] = 1'b0;
        end else begin : g_store
            logic [WIDTH-1:0] reg_q;
            logic             busy_q;
            logic             busy_d;
            logic             wen;
            assign wen = regwrite && (wr == AW'(i));
            // a newly issued producer outranks the write-back clearing the flag
            assign busy_d = (set_busy && (set_addr == AW'(i))) || (busy_q && !wen);
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    reg_q  <= '0;
                    busy_q <= 1'b0;
                end else begin
                    reg_q  <= wen ? wd : reg_q;
                    busy_q <= busy_d;
                end
            end
            assign regs[i] = reg_q;
            assign busy[i] = busy_q;
        end
    end
    assign rd1 = (ZERO_REG && rr1 == '0) ? '0 : (BYPASS && regwrite && rr1 == wr) ? wd : regs[rr1];
    assign rd2 = (ZERO_REG && rr2 == '0) ? '0 : (BYPASS && regwrite && rr2 == wr) ? wd : regs[rr2];
    assign busy1    = busy[rr1];
    assign busy2    = busy[rr2];
    assign busy_vec = busy;
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: vector table plus post-edge scoreboard over three parameterisations.
module tb_reg_file_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, sb;
    logic [1:0]  wr, sa, r1, r2;
    logic [15:0] wd;
    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        b1_a, b2_a, b1_b, b2_b;
    logic [3:0]  bv_a, bv_b;
    logic        we8, sb8;
    logic [2:0]  wr8, sa8, r18, r28;
    logic [31:0] wd8, rd18, rd28;
    logic        b18, b28;
    logic [7:0]  bv8;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    reg_file_param u_a (
        .clock(clk), .reset_n(rst_n), .rr1(r1), .rr2(r2), .rd1(rd1_a), .rd2(rd2_a),
        .regwrite(we), .wr(wr), .wd(wd), .set_busy(sb), .set_addr(sa),
        .busy1(b1_a), .busy2(b2_a), .busy_vec(bv_a)
    );
    reg_file_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clock(clk), .reset_n(rst_n), .rr1(r1), .rr2(r2), .rd1(rd1_b), .rd2(rd2_b),
        .regwrite(we), .wr(wr), .wd(wd), .set_busy(sb), .set_addr(sa),
        .busy1(b1_b), .busy2(b2_b), .busy_vec(bv_b)
    );
    reg_file_param #(.WIDTH(32), .DEPTH(8)) u_c (
        .clock(clk), .reset_n(rst_n), .rr1(r18), .rr2(r28), .rd1(rd18), .rd2(rd28),
        .regwrite(we8), .wr(wr8), .wd(wd8), .set_busy(sb8), .set_addr(sa8),
        .busy1(b18), .busy2(b28), .busy_vec(bv8)
    );

    typedef struct {
        logic we; logic [1:0] wr; logic [15:0] wd; logic sb; logic [1:0] sa;
        logic [1:0] r1, r2;
        logic [15:0] pre_a, pre_b; logic pb1;
        logic [15:0] po1, po2, pob; logic [3:0] bva, bvb; logic pob1;
    } vec_t;
    typedef struct {
        logic [15:0] po1, po2, pob; logic [3:0] bva, bvb; logic pob1;
    } post_t;

    vec_t        vecs[15];
    post_t       q[$];
    logic [31:0] q8[$];

    function automatic vec_t mk(logic w, logic [1:0] a, logic [15:0] d, logic s, logic [1:0] sad,
                                logic [1:0] x1, logic [1:0] x2, logic [15:0] pa, logic [15:0] pb,
                                logic pbb, logic [15:0] o1, logic [15:0] o2, logic [15:0] ob,
                                logic [3:0] va, logic [3:0] vb, logic ob1);
        vec_t v;
        v.we = w; v.wr = a; v.wd = d; v.sb = s; v.sa = sad; v.r1 = x1; v.r2 = x2;
        v.pre_a = pa; v.pre_b = pb; v.pb1 = pbb; v.po1 = o1; v.po2 = o2; v.pob = ob;
        v.bva = va; v.bvb = vb; v.pob1 = ob1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        post_t p;
        logic [31:0] e;
        vecs[0]  = mk(1, 1, 16'h1111, 0, 0, 1, 3, 16'h1111, 16'h0000, 0, 16'h1111, 16'h0000, 16'h1111, 4'h0, 4'h0, 0);
        vecs[1]  = mk(1, 2, 16'h2222, 0, 0, 2, 1, 16'h2222, 16'h0000, 0, 16'h2222, 16'h1111, 16'h2222, 4'h0, 4'h0, 0);
        vecs[2]  = mk(1, 3, 16'h3333, 0, 0, 1, 3, 16'h1111, 16'h1111, 0, 16'h1111, 16'h3333, 16'h1111, 4'h0, 4'h0, 0);
        vecs[3]  = mk(1, 0, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'hFFFF, 4'h0, 4'h0, 0);
        vecs[4]  = mk(0, 2, 16'hAAAA, 0, 0, 2, 3, 16'h2222, 16'h2222, 0, 16'h2222, 16'h3333, 16'h2222, 4'h0, 4'h0, 0);
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = mk(1, 3, 16'h5A5A, 0, 0, 3, 1, 16'h5A5A, 16'h3333, 0, 16'h5A5A, 16'h1111, 16'h5A5A, 4'h0, 4'h0, 0);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 2, 2, 0, 16'h2222, 16'h2222, 0, 16'h2222, 16'h0000, 16'h2222, 4'h4, 4'h4, 1);
        vecs[9]  = mk(1, 2, 16'h1234, 0, 0, 2, 3, 16'h1234, 16'h2222, 1, 16'h1234, 16'h5A5A, 16'h1234, 4'h0, 4'h0, 0);
        vecs[10] = mk(1, 2, 16'h4321, 1, 2, 2, 2, 16'h4321, 16'h1234, 0, 16'h4321, 16'h4321, 16'h4321, 4'h4, 4'h4, 1);
        vecs[11] = mk(1, 2, 16'h5555, 1, 3, 2, 3, 16'h5555, 16'h4321, 1, 16'h5555, 16'h5A5A, 16'h5555, 4'h8, 4'h8, 0);
        vecs[12] = mk(0, 0, 16'h0000, 1, 0, 0, 3, 16'h0000, 16'hFFFF, 0, 16'h0000, 16'h5A5A, 16'hFFFF, 4'h8, 4'h9, 0);
        vecs[13] = mk(0, 0, 16'h0000, 1, 3, 3, 0, 16'h5A5A, 16'h5A5A, 1, 16'h5A5A, 16'h0000, 16'h5A5A, 4'h8, 4'h9, 1);
        vecs[14] = mk(1, 0, 16'h0000, 0, 0, 3, 0, 16'h5A5A, 16'h5A5A, 1, 16'h5A5A, 16'h0000, 16'h5A5A, 4'h8, 4'h8, 1);

        rst_n = 1'b0;
        {we, sb, wr, sa, r1, r2, wd} = '0;
        {we8, sb8, wr8, sa8, r18, r28, wd8} = '0;
        #1;
        chk("reset rd1_a", rd1_a, 16'h0);
        chk("reset rd1_b", rd1_b, 16'h0);
        chk("reset bv_a", bv_a, 4'h0);
        chk("reset bv8", bv8, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            we = vecs[k].we; wr = vecs[k].wr; wd = vecs[k].wd;
            sb = vecs[k].sb; sa = vecs[k].sa; r1 = vecs[k].r1; r2 = vecs[k].r2;
            q.push_back('{vecs[k].po1, vecs[k].po2, vecs[k].pob, vecs[k].bva, vecs[k].bvb, vecs[k].pob1});
            #1;
            chk($sformatf("v%0d pre rd1_a", k), rd1_a, vecs[k].pre_a);
            chk($sformatf("v%0d pre rd1_b", k), rd1_b, vecs[k].pre_b);
            chk($sformatf("v%0d pre busy1_a", k), b1_a, vecs[k].pb1);
            @(posedge clk);
            #1;
            p = q.pop_front();
            chk($sformatf("v%0d post rd1_a", k), rd1_a, p.po1);
            chk($sformatf("v%0d post rd2_a", k), rd2_a, p.po2);
            chk($sformatf("v%0d post rd1_b", k), rd1_b, p.pob);
            chk($sformatf("v%0d post bv_a", k), bv_a, p.bva);
            chk($sformatf("v%0d post bv_b", k), bv_b, p.bvb);
            chk($sformatf("v%0d post busy1_a", k), b1_a, p.pob1);
        end

        @(negedge clk);
        we = 1'b1; wr = 2; wd = 16'hBEEF; sb = 1'b0; r1 = 2; r2 = 3;
        @(posedge clk);
        #1;
        chk("beef written", rd1_a, 16'hBEEF);
        #2;
        we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async reset rd1_a", rd1_a, 16'h0);
        chk("async reset rd1_b", rd1_b, 16'h0);
        chk("async reset bv_a", bv_a, 4'h0);
        chk("async reset bv_b", bv_b, 4'h0);
        chk("async reset busy2_a", b2_a, 1'b0);
        we = 1'b1; wr = 1; wd = 16'h7777; r1 = 1;
        #1;
        chk("reset bypass rd1_a", rd1_a, 16'h7777);
        chk("reset nobypass rd1_b", rd1_b, 16'h0);
        @(posedge clk);
        #1;
        chk("write ignored in reset", rd1_b, 16'h0);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;

        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we8 = 1'b1; wr8 = 3'(i); wd8 = {8'hA5, 8'(i), 8'h5A, 8'(i * 3)};
            sb8 = 1'b1; sa8 = 3'(i - 1);
            q8.push_back(wd8);
            @(posedge clk);
        end
        @(negedge clk);
        we8 = 1'b0; sb8 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            r18 = 3'(i); r28 = 3'(i);
            #1;
            e = q8.pop_front();
            chk($sformatf("w32 rd1 r%0d", i), rd18, e);
            chk($sformatf("w32 rd2 r%0d", i), rd28, e);
        end
        chk("w32 busy_vec", bv8, 8'h7E);
        chk("w32 busy1 r7", b18, 1'b0);
        r18 = 6; r28 = 0;
        #1;
        chk("w32 busy1 r6", b18, 1'b1);
        chk("w32 rd2 r0", rd28, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
